// File: rtl/hs32_fetch.sv
// Instruction fetch controller: owns the fetch PC, issues one word read at a time into a
// 2-entry prefetch buffer, and hands buffered instructions to decode over reqd/ackd.
module hs32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] maddr,
  output logic        mreq,
  input  logic        mack,
  input  logic [31:0] mdata,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        ackd,
  input  logic        reqd,
  input  logic        flush,
  input  logic [31:0] newpc
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;
  logic [31:0] r_drain_addr, w_drain_addr_next;
  logic [31:0] r_buf_pc   [2];
  logic [31:0] r_buf_inst [2];
  logic        r_head;
  logic [1:0]  r_count, w_count_next;
  logic        w_ack, w_push, w_pop, w_tail, w_space;
  logic        w_unused_newpc;

  assign w_unused_newpc = ^newpc[1:0];

  assign ackd   = (r_count != 2'd0);
  assign w_pop  = reqd && ackd;
  assign w_ack  = mack && (r_state != StIdle);
  assign w_push = (r_state == StFetch) && mack && !flush;
  // A push only happens with at most one entry held, so the tail is head + count[0].
  assign w_tail = r_head ^ r_count[0];

  assign mreq  = (r_state != StIdle);
  assign maddr = (r_state == StDrain) ? r_drain_addr : r_fetch_pc;
  assign instd = ackd ? r_buf_inst[r_head] : 32'h0;
  assign pcd   = ackd ? r_buf_pc[r_head] : 32'h0;

  always_comb begin
    w_count_next      = r_count;
    w_fetch_pc_next   = r_fetch_pc;
    w_drain_addr_next = r_drain_addr;
    w_state_next      = r_state;

    if (flush) begin
      w_count_next = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 2'd1;
    end

    // No request is outstanding whenever this is consulted, so free = 2 - count_next.
    w_space = (w_count_next != 2'd2);

    if (flush) begin
      w_fetch_pc_next = {newpc[31:2], 2'b00};
    end else if (w_push) begin
      w_fetch_pc_next = r_fetch_pc + 32'd4;
    end

    unique case (r_state)
      StIdle: begin
        if (w_space) w_state_next = StFetch;
      end
      StFetch: begin
        if (w_ack) begin
          w_state_next = w_space ? StFetch : StIdle;
        end else if (flush) begin
          // The bus request must complete; remember the abandoned address.
          w_state_next      = StDrain;
          w_drain_addr_next = r_fetch_pc;
        end
      end
      StDrain: begin
        if (w_ack) w_state_next = w_space ? StFetch : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_fetch_pc   <= ResetPcAligned;
      r_drain_addr <= ResetPcAligned;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_drain_addr <= w_drain_addr_next;
      r_count      <= w_count_next;
      if (w_pop && !flush) r_head <= ~r_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_buf_pc[w_tail]   <= r_fetch_pc;
      r_buf_inst[w_tail] <= mdata;
    end
  end

endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: directed vector table for the corner cases, then random traffic
// against a transaction-level model (instruction queue plus one pending bus read).
module tb_hs32_fetch;

  logic        clk = 1'b0;
  logic        reset, mack, reqd, flush;
  logic [31:0] mdata, newpc;
  logic        mreq, ackd;
  logic [31:0] maddr, instd, pcd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hs32_fetch dut (
    .clk   (clk),
    .reset (reset),
    .maddr (maddr),
    .mreq  (mreq),
    .mack  (mack),
    .mdata (mdata),
    .instd (instd),
    .pcd   (pcd),
    .ackd  (ackd),
    .reqd  (reqd),
    .flush (flush),
    .newpc (newpc)
  );

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
  entry_t      m_buf[$];
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_addr = 32'h0;
  logic        m_pend = 1'b0;
  logic        m_disc = 1'b0;

  typedef struct {
    logic [3:0]  ctl;  // {reset, flush, reqd, mack}
    logic [31:0] npc;
    logic        exp_mreq;
    logic [31:0] exp_maddr;
    logic        exp_ackd;
    logic [31:0] exp_pcd;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic ack, pop;
    if (reset) begin
      m_buf.delete();
      m_pc   = 32'h0;
      m_pend = 1'b0;
      m_disc = 1'b0;
      return;
    end
    ack = m_pend && mack;
    pop = reqd && (m_buf.size() != 0);
    if (flush) begin
      m_buf.delete();
      m_pc = {newpc[31:2], 2'b00};
      if (ack) begin
        m_pend = 1'b0;
        m_disc = 1'b0;
      end else if (m_pend) begin
        m_disc = 1'b1;
      end
    end else begin
      if (pop) void'(m_buf.pop_front());
      if (ack) begin
        if (!m_disc) begin
          m_buf.push_back('{pc: m_addr, inst: mdata});
          m_pc = m_pc + 32'd4;
        end
        m_pend = 1'b0;
        m_disc = 1'b0;
      end
    end
    // With nothing in flight and room in the buffer, a read at fetch_pc starts next cycle.
    if (!m_pend && m_buf.size() < 2) begin
      m_pend = 1'b1;
      m_addr = m_pc;
    end
  endtask

  task automatic compare_model();
    logic        has;
    logic [31:0] exp_pc, exp_inst;
    has      = (m_buf.size() != 0);
    exp_pc   = has ? m_buf[0].pc : 32'h0;
    exp_inst = has ? m_buf[0].inst : 32'h0;
    chk("model_mreq", 32'(mreq), 32'(m_pend));
    chk("model_maddr", maddr, m_pend ? m_addr : m_pc);
    chk("model_ackd", 32'(ackd), 32'(has));
    chk("model_pcd", pcd, exp_pc);
    chk("model_instd", instd, exp_inst);
  endtask

  // Inputs are already driven; advance one clock and check at the following falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic add(input logic [3:0] ctl, input logic [31:0] npc, input logic em,
                     input logic [31:0] ea, input logic ek, input logic [31:0] ep);
    vecs.push_back('{ctl: ctl, npc: npc, exp_mreq: em, exp_maddr: ea, exp_ackd: ek,
                     exp_pcd: ep});
  endtask

  initial begin
    int wait_mode;
    reset = 1'b1;
    mack  = 1'b0;
    reqd  = 1'b0;
    flush = 1'b0;
    newpc = 32'h0;
    mdata = 32'h0;

    // ctl = {reset, flush, reqd, mack}; expectations are seen one cycle after the inputs
    add(4'b1000, 32'h0,     1'b0, 32'h0,     1'b0, 32'h0);
    add(4'b0000, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0);
    add(4'b0001, 32'h0,     1'b1, 32'h4,     1'b1, 32'h0);
    add(4'b0001, 32'h0,     1'b0, 32'h8,     1'b1, 32'h0);
    add(4'b0001, 32'h0,     1'b0, 32'h8,     1'b1, 32'h0);  // mack with mreq low
    add(4'b0010, 32'h0,     1'b1, 32'h8,     1'b1, 32'h4);
    add(4'b0100, 32'h103,   1'b1, 32'h8,     1'b0, 32'h0);  // flush while 0x8 pending
    add(4'b0000, 32'h0,     1'b1, 32'h8,     1'b0, 32'h0);
    add(4'b0001, 32'h0,     1'b1, 32'h100,   1'b0, 32'h0);  // drain ack discarded
    add(4'b0001, 32'h0,     1'b1, 32'h104,   1'b1, 32'h100);
    add(4'b0101, 32'h200,   1'b1, 32'h200,   1'b0, 32'h0);  // flush with mack
    add(4'b0011, 32'h0,     1'b1, 32'h204,   1'b1, 32'h200);
    add(4'b0011, 32'h0,     1'b1, 32'h208,   1'b1, 32'h204);
    add(4'b1001, 32'h0,     1'b0, 32'h0,     1'b0, 32'h0);  // reset mid-fetch with mack
    add(4'b0000, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0);
    add(4'b0000, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0);  // three wait states
    add(4'b0000, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0);
    add(4'b0000, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0);
    add(4'b0001, 32'h0,     1'b1, 32'h4,     1'b1, 32'h0);
    add(4'b0110, 32'hFFFF_FFFC, 1'b1, 32'h4, 1'b0, 32'h0);
    add(4'b0001, 32'h0,     1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    add(4'b0001, 32'h0,     1'b1, 32'h0,     1'b1, 32'hFFFF_FFFC);  // PC wraps

    @(negedge clk);
    foreach (vecs[i]) begin
      {reset, flush, reqd, mack} = vecs[i].ctl;
      newpc = vecs[i].npc;
      mdata = m_pend ? memfn(m_addr) : 32'hDEAD_0000;
      cycle();
      chk($sformatf("vec%0d_mreq", i), 32'(mreq), 32'(vecs[i].exp_mreq));
      chk($sformatf("vec%0d_maddr", i), maddr, vecs[i].exp_maddr);
      chk($sformatf("vec%0d_ackd", i), 32'(ackd), 32'(vecs[i].exp_ackd));
      chk($sformatf("vec%0d_pcd", i), pcd, vecs[i].exp_pcd);
    end

    wait_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) wait_mode = $urandom_range(0, 3);
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 24) == 0);
      newpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      reqd  = $urandom_range(0, 1) == 1;
      mack  = (wait_mode == 0) ? 1'b1 : ($urandom_range(0, wait_mode) == 0);
      mdata = m_pend ? memfn(m_addr) : $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
